muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; the data width SHALL be fixed at 32 bits.
REQ-002 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 i_reset  input  1  asynchronous, active-high reset.
REQ-004 i_start  input  1  request pulse; accepted only in IDLE.
REQ-005 i_md_op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 i_op_a  input  32  rs1 operand (multiplicand/dividend).
REQ-007 i_op_b  input  32  rs2 operand (multiplier/divisor).
REQ-008 i_flush  input  1  synchronous abort from pipeline control.
REQ-009 o_busy  output  1  high while an operation is in flight (CALC or DONE).
REQ-010 o_valid  output  1  one-cycle pulse marking o_md_data as the result.
REQ-011 o_md_data  output  32  result; held stable from o_valid until the next accepted start.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 In IDLE with i_start=1 and i_flush=0, the block SHALL latch i_md_op, i_op_a and i_op_b, clear a 5-bit iteration counter and go to CALC.
REQ-014 i_start in CALC or DONE SHALL be ignored; operands on the bus SHALL NOT affect the in-flight operation.
REQ-015 CALC SHALL perform one radix-2 iteration per cycle for exactly 32 cycles (counter 0..31), then go to DONE.
REQ-016 Multiply SHALL use shift-add on operand magnitudes, producing a 64-bit product and a sign fix-up in DONE.
REQ-017 Multiply signedness: MUL/MULH treat both operands as signed; MULHSU treats a as signed and b as unsigned; MULHU treats both as unsigned.
REQ-018 MUL SHALL return product[31:0]; MULH/MULHSU/MULHU SHALL return product[63:32].
REQ-019 Divide SHALL use restoring division on magnitudes; the quotient sign SHALL be sign(a) XOR sign(b) and the remainder sign SHALL equal sign(a) (truncating division).
REQ-020 Divisor zero SHALL return quotient 0xFFFFFFFF and remainder equal to a, for both signed and unsigned ops.
REQ-021 Signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV/REM) SHALL return quotient 0x80000000 and remainder 0.
REQ-022 The special cases in REQ-020/021 SHALL keep the full 34-cycle latency; there SHALL be no early-out path.
REQ-023 DONE SHALL last exactly one cycle: o_valid=1 and o_md_data updated, then return to IDLE.
REQ-024 Latency: if start is accepted at edge N, o_valid SHALL be high in the cycle after edge N+33, and o_busy SHALL be high from edge N+1 through the DONE cycle.
REQ-025 i_start is accepted again in the first IDLE cycle after DONE, giving back-to-back throughput of one op per 34 cycles.
REQ-026 i_flush=1 in any state SHALL force IDLE at the next edge with no o_valid pulse, and o_md_data SHALL be left unchanged.
REQ-027 i_flush=1 together with i_start=1 in IDLE SHALL reject the start; flush has priority.
REQ-028 o_valid SHALL never be asserted outside DONE.

Reset
REQ-029 Asserting i_reset SHALL immediately, without a clock edge, force IDLE, o_busy=0, o_valid=0, o_md_data=0, and clear the counter and all operand/accumulator registers.
REQ-030 Reset asserted mid-operation SHALL discard that operation; no o_valid pulse SHALL follow deassertion.
REQ-031 After reset deasserts, the first rising edge with i_start=1 SHALL be accepted normally.

Verification
REQ-032 Multiply cases SHALL produce:
- MUL 7, 0xFFFFFFFD -> 0xFFFFFFEB
- MULH 0x80000000, 0x80000000 -> 0x40000000
- MULHU 0xFFFFFFFF, 0xFFFFFFFF -> 0xFFFFFFFE
- MULHSU 0xFFFFFFFF, 0xFFFFFFFF -> 0xFFFFFFFF
Each SHALL have o_valid exactly 34 cycles after the start edge.
REQ-033 Divide cases SHALL produce:
- DIV 0xFFFFFFF9 (-7), 2 -> 0xFFFFFFFD
- REM -7, 2 -> 0xFFFFFFFF
- DIVU 100, 7 -> 0x0000000E
- REMU 100, 7 -> 0x00000002
REQ-034 Corner cases SHALL produce:
- DIV 5, 0 -> 0xFFFFFFFF
- REMU 5, 0 -> 0x00000005
- DIV 0x80000000, 0xFFFFFFFF -> 0x80000000
- REM 0x80000000, 0xFFFFFFFF -> 0
REQ-035 Start handling: i_start re-pulsed with new operands at cycle 5 of a MUL 3, 4 -> that pulse is ignored and the result is 0x0000000C; a start in the cycle after o_valid is accepted.
REQ-036 Flush: i_flush at CALC cycle 10 -> o_busy=0 next cycle, no o_valid, o_md_data keeps its prior value; a following DIVU 9, 3 -> 0x00000003.
REQ-037 Reset: i_reset pulsed mid-CALC between clock edges -> outputs are 0 immediately, no o_valid afterwards, and the next start completes correctly.

Source files
------------

// File: rtl/muldiv_if.sv
// Request/result bus of the RV32M multiply/divide unit.
// The pipeline side uses the master modport and the unit uses the slave modport.
interface muldiv_if;
  logic        i_start;
  logic [2:0]  i_md_op;
  logic [31:0] i_op_a;
  logic [31:0] i_op_b;
  logic        i_flush;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_md_data;

  modport master (
    output i_start, i_md_op, i_op_a, i_op_b, i_flush,
    input  o_busy, o_valid, o_md_data
  );

  modport slave (
    input  i_start, i_md_op, i_op_a, i_op_b, i_flush,
    output o_busy, o_valid, o_md_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Both multiply and divide work on operand magnitudes in a shared 64-bit accumulator.
// Each CALC cycle runs one radix-2 step: shift-add for multiply, restoring subtraction for divide.
// The sign fix-up and result selection happen in DONE.
// Status outputs are registered one cycle behind the FSM, so a start taken at edge N
// gives o_busy from edge N+1 and o_valid in the cycle after edge N+33.
module muldiv_unit (
  input  logic     i_clk,
  input  logic     i_reset,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] opnd_q, opnd_d;    // addend (multiply) or divisor (divide) magnitude
  logic [63:0] acc_q, acc_d;      // product, or {remainder, quotient}
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;      // negate product / quotient
  logic        rneg_q, rneg_d;    // negate remainder
  logic        bzero_q, bzero_d;  // divisor was zero
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;

  // Operand decode for the incoming request
  logic        in_div, a_signed, b_signed, a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  assign in_div   = bus.i_md_op[2];
  assign a_signed = in_div ? ~bus.i_md_op[0] : (bus.i_md_op[1:0] != 2'b11);
  assign b_signed = in_div ? ~bus.i_md_op[0] : ~bus.i_md_op[1];
  assign a_neg    = a_signed & bus.i_op_a[31];
  assign b_neg    = b_signed & bus.i_op_b[31];
  assign mag_a    = a_neg ? (32'd0 - bus.i_op_a) : bus.i_op_a;
  assign mag_b    = b_neg ? (32'd0 - bus.i_op_b) : bus.i_op_b;

  // One radix-2 step of each algorithm
  logic [32:0] mul_sum, div_trial;
  logic [63:0] mul_step, div_step;
  assign mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
  assign mul_step  = {mul_sum, acc_q[31:1]};
  assign div_trial = acc_q[63:31] - {1'b0, opnd_q};
  assign div_step  = div_trial[32] ? {acc_q[62:0], 1'b0}
                                   : {div_trial[31:0], acc_q[30:0], 1'b1};

  // Sign fix-up and result selection. The signed-overflow case produces 0x80000000/0 naturally.
  logic [63:0] prod;
  logic [31:0] quo, rem, result;
  assign prod = neg_q ? (64'd0 - acc_q) : acc_q;
  assign quo  = bzero_q ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0]);
  assign rem  = rneg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

  // Select the architectural result for the latched funct3
  always_comb begin
    result = rem;
    case (op_q)
      3'b000:                 result = prod[31:0];
      3'b001, 3'b010, 3'b011: result = prod[63:32];
      3'b100, 3'b101:         result = quo;
      default:                result = rem;
    endcase
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    bzero_d = bzero_q;
    busy_d  = (state_q != IDLE) && !bus.i_flush;
    valid_d = (state_q == DONE) && !bus.i_flush;
    data_d  = valid_d ? result : data_q;
    case (state_q)
      IDLE: begin
        if (bus.i_start && !bus.i_flush) begin
          state_d = CALC;
          op_d    = bus.i_md_op;
          cnt_d   = 5'd0;
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          bzero_d = (bus.i_op_b == 32'd0);
          opnd_d  = in_div ? mag_b : mag_a;
          acc_d   = in_div ? {32'd0, mag_a} : {32'd0, mag_b};
        end
      end
      CALC: begin
        if (bus.i_flush) begin
          state_d = IDLE;
        end else begin
          acc_d = op_q[2] ? div_step : mul_step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      op_q    <= 3'd0;
      opnd_q  <= 32'd0;
      acc_q   <= 64'd0;
      cnt_q   <= 5'd0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      bzero_q <= bzero_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign bus.o_busy    = busy_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_md_data = data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors, corner cases,
// start/flush/reset handling and randomized operations against an arithmetic model.
module tb_muldiv_unit;

  logic clk;
  logic rst;
  muldiv_if bus_if ();

  muldiv_unit dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus_if)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_exp = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result computed directly from RV32M arithmetic rules
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    case (op)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Issue one operation and observe it; busy/pulse flags record protocol behaviour.
  // repulse_at > 0 re-pulses i_start with junk operands that many edges after acceptance.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int repulse_at, output logic [31:0] res, output int lat,
                        output bit busy_ok, output bit pulse_ok);
    @(negedge clk);
    bus_if.i_start = 1'b1;
    bus_if.i_md_op = op;
    bus_if.i_op_a  = a;
    bus_if.i_op_b  = b;
    @(negedge clk);
    bus_if.i_start = 1'b0;
    bus_if.i_md_op = 3'($urandom_range(0, 7));
    bus_if.i_op_a  = $urandom;
    bus_if.i_op_b  = $urandom;
    lat = -1;
    res = 32'd0;
    busy_ok = 1'b1;
    pulse_ok = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      bus_if.i_start = 1'b0;
      if (bus_if.o_valid === 1'b1) begin
        lat = k;
        res = bus_if.o_md_data;
        if (bus_if.o_busy !== 1'b1) busy_ok = 1'b0;
        break;
      end
      if (bus_if.o_busy !== 1'b1) busy_ok = 1'b0;
      if (k == repulse_at) begin
        bus_if.i_start = 1'b1;
        bus_if.i_md_op = 3'($urandom_range(0, 7));
        bus_if.i_op_a  = $urandom;
        bus_if.i_op_b  = $urandom;
      end
    end
    @(negedge clk);
    if (bus_if.o_valid !== 1'b0 || bus_if.o_busy !== 1'b0 || bus_if.o_md_data !== res) pulse_ok = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus_if.i_start = 1'b0;
    bus_if.i_flush = 1'b0;
    bus_if.i_md_op = 3'd0;
    bus_if.i_op_a  = 32'd0;
    bus_if.i_op_b  = 32'd0;
    #12;
    checks++;
    if (bus_if.o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b expected 0", bus_if.o_busy); end
    checks++;
    if (bus_if.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b expected 0", bus_if.o_valid); end
    checks++;
    if (bus_if.o_md_data !== 32'd0) begin failures++; $display("FAIL reset_data got %h expected 00000000", bus_if.o_md_data); end
    @(negedge clk);
    rst = 1'b0;
    $display("reset: busy=%b valid=%b data=%h", bus_if.o_busy, bus_if.o_valid, bus_if.o_md_data);
  endtask

  task automatic test_mul_vectors;
    logic [2:0]  t_op  [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
    logic [31:0] t_a   [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_b   [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_exp [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] res;
    int lat;
    bit bok, pok;
    for (int i = 0; i < 4; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], 0, res, lat, bok, pok);
      $display("mul op=%0d a=%h b=%h -> %h lat=%0d", t_op[i], t_a[i], t_b[i], res, lat);
      checks++;
      if (res !== t_exp[i]) begin failures++; $display("FAIL mul_vec[%0d] result got %h expected %h", i, res, t_exp[i]); end
      checks++;
      if (lat !== 33) begin failures++; $display("FAIL mul_vec[%0d] latency got %0d expected 33", i, lat); end
      checks++;
      if (!bok || !pok) begin failures++; $display("FAIL mul_vec[%0d] busy/pulse got %0d/%0d expected 1/1", i, bok, pok); end
      last_exp = t_exp[i];
    end
  endtask

  task automatic test_div_vectors;
    logic [2:0]  t_op  [8] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] t_a   [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                               32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] t_b   [8] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_exp [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0000_000E, 32'h0000_0002,
                               32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'h0000_0000};
    logic [31:0] res;
    int lat;
    bit bok, pok;
    for (int i = 0; i < 8; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], 0, res, lat, bok, pok);
      $display("div op=%0d a=%h b=%h -> %h lat=%0d", t_op[i], t_a[i], t_b[i], res, lat);
      checks++;
      if (res !== t_exp[i]) begin failures++; $display("FAIL div_vec[%0d] result got %h expected %h", i, res, t_exp[i]); end
      checks++;
      if (lat !== 33) begin failures++; $display("FAIL div_vec[%0d] latency got %0d expected 33", i, lat); end
      last_exp = t_exp[i];
    end
  endtask

  task automatic test_start_ignored;
    logic [31:0] res;
    int lat;
    bit bok, pok;
    run_op(3'd0, 32'd3, 32'd4, 5, res, lat, bok, pok);
    $display("start_ignored: MUL 3,4 with re-pulse -> %h lat=%0d", res, lat);
    checks++;
    if (res !== 32'h0000_000C) begin failures++; $display("FAIL start_ignored result got %h expected 0000000c", res); end
    checks++;
    if (lat !== 33) begin failures++; $display("FAIL start_ignored latency got %0d expected 33", lat); end
    checks++;
    if (!pok) begin failures++; $display("FAIL start_ignored pulse_clean got %0d expected 1", pok); end
    last_exp = 32'h0000_000C;
  endtask

  task automatic test_back_to_back;
    logic [31:0] res;
    int lat;
    bit bok, pok;
    for (int i = 0; i < 3; i++) begin
      logic [2:0]  op = 3'($urandom_range(0, 7));
      logic [31:0] a  = $urandom;
      logic [31:0] b  = $urandom;
      logic [31:0] exp_v = ref_model(op, a, b);
      run_op(op, a, b, 0, res, lat, bok, pok);
      $display("back_to_back[%0d] op=%0d a=%h b=%h -> %h lat=%0d", i, op, a, b, res, lat);
      checks++;
      if (res !== exp_v || lat !== 33) begin
        failures++;
        $display("FAIL back_to_back[%0d] result/lat got %h/%0d expected %h/33", i, res, lat, exp_v);
      end
      last_exp = exp_v;
    end
  endtask

  task automatic test_flush;
    logic [31:0] res;
    int lat;
    bit bok, pok, seen;
    @(negedge clk);
    bus_if.i_start = 1'b1;
    bus_if.i_md_op = 3'd5;
    bus_if.i_op_a  = 32'd1000;
    bus_if.i_op_b  = 32'd7;
    @(negedge clk);
    bus_if.i_start = 1'b0;
    repeat (10) @(negedge clk);
    bus_if.i_flush = 1'b1;
    @(negedge clk);
    bus_if.i_flush = 1'b0;
    $display("flush: busy=%b valid=%b data=%h", bus_if.o_busy, bus_if.o_valid, bus_if.o_md_data);
    checks++;
    if (bus_if.o_busy !== 1'b0) begin failures++; $display("FAIL flush_busy got %b expected 0", bus_if.o_busy); end
    checks++;
    if (bus_if.o_md_data !== last_exp) begin failures++; $display("FAIL flush_data got %h expected %h", bus_if.o_md_data, last_exp); end
    seen = 1'b0;
    for (int k = 0; k < 45; k++) begin
      if (bus_if.o_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin failures++; $display("FAIL flush_no_valid got valid=1 expected none"); end
    run_op(3'd5, 32'd9, 32'd3, 0, res, lat, bok, pok);
    $display("after flush: DIVU 9,3 -> %h lat=%0d", res, lat);
    checks++;
    if (res !== 32'd3 || lat !== 33) begin failures++; $display("FAIL flush_followup result/lat got %h/%0d expected 00000003/33", res, lat); end
    last_exp = 32'd3;
  endtask

  task automatic test_flush_start_idle;
    bit seen;
    @(negedge clk);
    bus_if.i_start = 1'b1;
    bus_if.i_flush = 1'b1;
    bus_if.i_md_op = 3'd0;
    bus_if.i_op_a  = 32'd2;
    bus_if.i_op_b  = 32'd2;
    @(negedge clk);
    bus_if.i_start = 1'b0;
    bus_if.i_flush = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus_if.o_valid !== 1'b0 || bus_if.o_busy !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    $display("flush_start_idle: activity=%0d", seen);
    checks++;
    if (seen) begin failures++; $display("FAIL flush_start_idle got busy/valid activity expected none"); end
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] res;
    int lat;
    bit bok, pok, seen;
    @(negedge clk);
    bus_if.i_start = 1'b1;
    bus_if.i_md_op = 3'd1;
    bus_if.i_op_a  = 32'h1234_5678;
    bus_if.i_op_b  = 32'h9ABC_DEF0;
    @(negedge clk);
    bus_if.i_start = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (bus_if.o_busy !== 1'b1) begin failures++; $display("FAIL reset_mid_pre_busy got %b expected 1", bus_if.o_busy); end
    #2 rst = 1'b1;
    #1;
    $display("reset_mid: busy=%b valid=%b data=%h", bus_if.o_busy, bus_if.o_valid, bus_if.o_md_data);
    checks++;
    if (bus_if.o_busy !== 1'b0 || bus_if.o_valid !== 1'b0 || bus_if.o_md_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs got busy=%b valid=%b data=%h expected 0/0/00000000",
               bus_if.o_busy, bus_if.o_valid, bus_if.o_md_data);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus_if.o_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin failures++; $display("FAIL reset_mid_no_valid got valid=1 expected none"); end
    run_op(3'd4, 32'hFFFF_FF9C, 32'd7, 0, res, lat, bok, pok);
    $display("after reset: DIV -100,7 -> %h lat=%0d", res, lat);
    checks++;
    if (res !== 32'hFFFF_FFF2 || lat !== 33) begin failures++; $display("FAIL reset_followup result/lat got %h/%0d expected fffffff2/33", res, lat); end
    last_exp = 32'hFFFF_FFF2;
  endtask

  task automatic test_random;
    logic [31:0] res;
    int lat;
    bit bok, pok;
    for (int i = 0; i < 30; i++) begin
      logic [2:0]  op = 3'($urandom_range(0, 7));
      logic [31:0] a  = $urandom;
      logic [31:0] b  = $urandom;
      logic [31:0] exp_v;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      exp_v = ref_model(op, a, b);
      run_op(op, a, b, 0, res, lat, bok, pok);
      $display("random[%0d] op=%0d a=%h b=%h -> %h lat=%0d", i, op, a, b, res, lat);
      checks++;
      if (res !== exp_v) begin failures++; $display("FAIL random[%0d] result got %h expected %h", i, res, exp_v); end
      checks++;
      if (lat !== 33 || !bok || !pok) begin
        failures++;
        $display("FAIL random[%0d] timing lat/busy/pulse got %0d/%0d/%0d expected 33/1/1", i, lat, bok, pok);
      end
      last_exp = exp_v;
    end
  endtask

  initial begin
    test_reset();
    test_mul_vectors();
    test_div_vectors();
    test_start_ignored();
    test_back_to_back();
    test_flush();
    test_flush_start_idle();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
